// File: rtl/sdram_word_bridge_pkg.sv
// Shared constants for the CPU-to-SDRAM word bridge: state encodings, address widths
// and the halfword-select bit values.
package sdram_word_bridge_pkg;

  localparam int CPU_AW_DEF   = 23;
  localparam int SDRAM_AW_DEF = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sdram_word_bridge.sv
// Splits one 32-bit CPU load/store into up to two 16-bit controller accesses, low half first.
// state | meaning
// IDLE  | waiting for cpu_req, latches the request when seen
// LO    | low halfword access at H, held until the controller's done pulse
// HI    | high halfword access at H+1, held until the controller's done pulse
// DONE  | one-cycle cpu_ready with the assembled read word
module sdram_word_bridge
  import sdram_word_bridge_pkg::*;
#(
  parameter int CPU_AW     = CPU_AW_DEF,
  parameter int SDRAM_AW   = SDRAM_AW_DEF,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic                sys_clk,
  input  logic                rstn,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [CPU_AW-1:0]   cpu_addr,
  input  logic [3:0]          cpu_wstrb,
  input  logic [31:0]         cpu_wdata,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_ready,
  output logic                cpu_busy,
  output logic [SDRAM_AW-1:0] avl_addr,
  output logic [1:0]          avl_byte_en,
  output logic                avl_WRITEen,
  output logic                avl_READen,
  output logic [15:0]         avl_WRDATA,
  input  logic [15:0]         avl_RDDATA,
  input  logic                avl_req_wait
);

  state_t              state, state_n;
  logic                we_q, we_n;
  logic [3:0]          wstrb_q, wstrb_n;
  logic [31:0]         wdata_q, wdata_n;
  logic [SDRAM_AW-1:0] base_q, base_n;
  logic                req_take;
  logic                access_done;

  logic [SDRAM_AW-1:0] addr_d;
  logic [1:0]          be_d;
  logic [15:0]         wrdata_d;
  logic                wr_en_d, rd_en_d, ready_d, busy_d;
  logic [31:0]         rdata_d;

  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign req_take    = (state == ST_IDLE) && cpu_req;
  assign access_done = !avl_req_wait;

  // Next request fields: the latch updates on the accept edge, so outputs must see inputs then.
  always_comb begin
    we_n    = req_take ? cpu_we    : we_q;
    wstrb_n = req_take ? cpu_wstrb : wstrb_q;
    wdata_n = req_take ? cpu_wdata : wdata_q;
    base_n  = req_take ? SDRAM_AW'({cpu_addr[CPU_AW-1:2], HALF_LO}) : base_q;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          if (!cpu_we || (cpu_wstrb[1:0] != 2'b00) || !SKIP_EMPTY) state_n = ST_LO;
          else if (cpu_wstrb[3:2] != 2'b00)                         state_n = ST_HI;
          else                                                      state_n = ST_DONE;
        end
      end
      ST_LO: begin
        if (access_done) begin
          if (we_q && (wstrb_q[3:2] == 2'b00) && SKIP_EMPTY) state_n = ST_DONE;
          else                                               state_n = ST_HI;
        end
      end
      ST_HI:   if (access_done) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state, so enables change on the done edge.
  always_comb begin
    addr_d   = avl_addr;
    be_d     = avl_byte_en;
    wrdata_d = avl_WRDATA;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    ready_d  = 1'b0;
    rdata_d  = cpu_rdata;
    if ((state == ST_LO) && access_done) rdata_d[15:0]  = avl_RDDATA;
    if ((state == ST_HI) && access_done) rdata_d[31:16] = avl_RDDATA;
    unique case (state_n)
      ST_LO: begin
        addr_d   = base_n;
        be_d     = we_n ? wstrb_n[1:0] : 2'b11;
        wrdata_d = wdata_n[15:0];
        wr_en_d  = we_n;
        rd_en_d  = !we_n;
      end
      ST_HI: begin
        addr_d   = {base_n[SDRAM_AW-1:1], HALF_HI};
        be_d     = we_n ? wstrb_n[3:2] : 2'b11;
        wrdata_d = wdata_n[31:16];
        wr_en_d  = we_n;
        rd_en_d  = !we_n;
      end
      ST_DONE: ready_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_n != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      base_q      <= '0;
      avl_addr    <= '0;
      avl_byte_en <= '0;
      avl_WRDATA  <= '0;
      avl_WRITEen <= 1'b0;
      avl_READen  <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_busy    <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      state       <= state_n;
      we_q        <= we_n;
      wstrb_q     <= wstrb_n;
      wdata_q     <= wdata_n;
      base_q      <= base_n;
      avl_addr    <= addr_d;
      avl_byte_en <= be_d;
      avl_WRDATA  <= wrdata_d;
      avl_WRITEen <= wr_en_d;
      avl_READen  <= rd_en_d;
      cpu_ready   <= ready_d;
      cpu_busy    <= busy_d;
      cpu_rdata   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Directed bench for sdram_word_bridge with a small SDRAM controller model and halfword memory.
module tb_sdram_word_bridge;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        cpu_req, cpu_we;
  logic [22:0] cpu_addr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_busy;
  logic [21:0] avl_addr;
  logic [1:0]  avl_byte_en;
  logic        avl_WRITEen, avl_READen;
  logic [15:0] avl_WRDATA;
  logic [15:0] avl_RDDATA;
  logic        avl_req_wait;

  int checks = 0;
  int errors = 0;

  sdram_word_bridge dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .avl_addr(avl_addr), .avl_byte_en(avl_byte_en),
    .avl_WRITEen(avl_WRITEen), .avl_READen(avl_READen),
    .avl_WRDATA(avl_WRDATA), .avl_RDDATA(avl_RDDATA), .avl_req_wait(avl_req_wait)
  );

  always #5 sys_clk = ~sys_clk;

  // Controller model: accepts an enable seen while idle, waits 1+refresh_extra cycles,
  // then pulses avl_req_wait low for one cycle and performs the access.
  logic [15:0] mem [0:255];
  logic        mem_loaded = 1'b0;
  logic        m_busy;
  int          m_cnt;
  logic [21:0] m_addr;
  logic [1:0]  m_be;
  logic [15:0] m_wd;
  logic        m_we;
  int          refresh_extra = 0;
  int          stab_err = 0;
  int          both_err = 0;
  logic [21:0] q_addr[$];
  logic [1:0]  q_be[$];
  logic        q_we[$];

  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      avl_req_wait <= 1'b1;
      avl_RDDATA   <= '0;
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        mem[8'h82] <= 16'hBEEF;
        mem[8'h83] <= 16'hDEAD;
        mem[8'h10] <= 16'h1111;
        mem[8'h11] <= 16'h2222;
        mem[8'h18] <= 16'h3344;
        mem[8'h19] <= 16'h5555;
        mem_loaded <= 1'b1;
      end
    end else begin
      if (avl_READen && avl_WRITEen) both_err <= both_err + 1;
      if (m_busy && ((avl_addr !== m_addr) || (avl_byte_en !== m_be) ||
                     (avl_WRITEen !== m_we) || (avl_READen !== !m_we) ||
                     (m_we && (avl_WRDATA !== m_wd))))
        stab_err <= stab_err + 1;
      if (!avl_req_wait) begin
        avl_req_wait <= 1'b1;
        m_busy       <= 1'b0;
      end else if (!m_busy) begin
        if (avl_READen || avl_WRITEen) begin
          m_busy <= 1'b1;
          m_cnt  <= 1 + refresh_extra;
          m_addr <= avl_addr;
          m_be   <= avl_byte_en;
          m_wd   <= avl_WRDATA;
          m_we   <= avl_WRITEen;
          q_addr.push_back(avl_addr);
          q_be.push_back(avl_byte_en);
          q_we.push_back(avl_WRITEen);
        end
      end else if (m_cnt == 0) begin
        avl_req_wait <= 1'b0;
        avl_RDDATA   <= mem[m_addr[7:0]];
        if (m_we)
          mem[m_addr[7:0]] <= {m_be[1] ? m_wd[15:8] : mem[m_addr[7:0]][15:8],
                               m_be[0] ? m_wd[7:0]  : mem[m_addr[7:0]][7:0]};
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, releases cpu_req after the accept edge, and waits (bounded) for ready.
  task automatic run_req(input logic we, input logic [22:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, output logic [31:0] rd,
                         output int nready, output int lat);
    nready = 0;
    lat    = 0;
    rd     = '0;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = data;
    @(negedge sys_clk);
    cpu_req = 1'b0;
    while (nready == 0 && lat < 300) begin
      lat++;
      if (cpu_ready) begin
        nready = 1;
        rd     = cpu_rdata;
      end else begin
        @(negedge sys_clk);
      end
    end
    repeat (3) begin
      @(negedge sys_clk);
      if (cpu_ready) nready++;
    end
  endtask

  logic [31:0] rd;
  int          nready, lat, qb, found;

  initial begin
    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_ready", {31'b0, cpu_ready}, 32'h0);
    check("rst_busy", {31'b0, cpu_busy}, 32'h0);
    check("rst_avl", {avl_addr, avl_byte_en, avl_WRITEen, avl_READen}, 32'h0);
    check("rst_wrdata", {16'h0, avl_WRDATA}, 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: load 0x104 -> halfwords 0x82, 0x83
    qb = q_addr.size();
    run_req(1'b0, 23'h000104, 4'b0000, 32'h0, rd, nready, lat);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_nready", nready, 1);
    check("t1_latency", lat, 9);
    check("t1_nacc", q_addr.size() - qb, 2);
    check("t1_addr0", {10'b0, q_addr[qb]}, 32'h82);
    check("t1_addr1", {10'b0, q_addr[qb+1]}, 32'h83);
    check("t1_be", {q_be[qb], q_be[qb+1]}, 32'hF);
    check("t1_we", {q_we[qb], q_we[qb+1]}, 32'h0);

    // 2: full store to 0x10 -> halfwords 0x8, 0x9
    qb = q_addr.size();
    run_req(1'b1, 23'h000010, 4'b1111, 32'h12345678, rd, nready, lat);
    check("t2_nready", nready, 1);
    check("t2_nacc", q_addr.size() - qb, 2);
    check("t2_addr", {q_addr[qb][7:0], q_addr[qb+1][7:0]}, 32'h0809);
    check("t2_we", {q_we[qb], q_we[qb+1]}, 32'h3);
    check("t2_mem", {mem[8'h09], mem[8'h08]}, 32'h12345678);

    // 3a: upper-half-only store to 0x20 -> only halfword 0x11 written
    qb = q_addr.size();
    run_req(1'b1, 23'h000020, 4'b1100, 32'hAABBCCDD, rd, nready, lat);
    check("t3a_nready", nready, 1);
    check("t3a_nacc", q_addr.size() - qb, 1);
    check("t3a_addr", {10'b0, q_addr[qb]}, 32'h11);
    check("t3a_be", {30'b0, q_be[qb]}, 32'h3);
    check("t3a_mem", {mem[8'h11], mem[8'h10]}, 32'hAABB1111);

    // 3b: single byte-1 store to 0x30 -> halfword 0x18 upper byte only
    qb = q_addr.size();
    run_req(1'b1, 23'h000030, 4'b0010, 32'h99887766, rd, nready, lat);
    check("t3b_nready", nready, 1);
    check("t3b_nacc", q_addr.size() - qb, 1);
    check("t3b_addr", {10'b0, q_addr[qb]}, 32'h18);
    check("t3b_be", {30'b0, q_be[qb]}, 32'h2);
    check("t3b_mem", {mem[8'h19], mem[8'h18]}, 32'h55557744);

    // 4: empty store -> no SDRAM access, ready right after accept
    qb = q_addr.size();
    run_req(1'b1, 23'h000040, 4'b0000, 32'hFFFFFFFF, rd, nready, lat);
    check("t4_nready", nready, 1);
    check("t4_latency", lat, 1);
    check("t4_nacc", q_addr.size() - qb, 0);

    // 5: long refresh in front of each access -> outputs held, single access per half
    refresh_extra = 12;
    qb = q_addr.size();
    run_req(1'b0, 23'h000010, 4'b0000, 32'h0, rd, nready, lat);
    refresh_extra = 0;
    check("t5_rdata", rd, 32'h12345678);
    check("t5_nready", nready, 1);
    check("t5_latency", lat, 33);
    check("t5_nacc", q_addr.size() - qb, 2);

    // 6: reset while the high half is in flight
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000104; cpu_wstrb = 4'b0000;
    @(negedge sys_clk);
    cpu_req = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (avl_READen && avl_addr[0]) found = 1;
      else @(negedge sys_clk);
    end
    check("t6_reached_hi", found, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_ctrl", {cpu_ready, cpu_busy, avl_WRITEen, avl_READen}, 32'h0);
    check("t6_rst_addr", {avl_byte_en, avl_addr}, 32'h0);
    check("t6_rst_rdata", cpu_rdata, 32'h0);
    check("t6_rst_wrdata", {16'h0, avl_WRDATA}, 32'h0);
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    @(negedge sys_clk);
    qb = q_addr.size();
    run_req(1'b0, 23'h000020, 4'b0000, 32'h0, rd, nready, lat);
    check("t6_rdata", rd, 32'hAABB1111);
    check("t6_nready", nready, 1);
    check("t6_nacc", q_addr.size() - qb, 2);

    // cpu_req held high: two back-to-back loads, each exactly two accesses
    qb = q_addr.size();
    nready = 0;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000104;
    for (int i = 0; i < 200 && nready < 2; i++) begin
      @(negedge sys_clk);
      if (cpu_ready) begin
        nready++;
        check("hold_rdata", cpu_rdata, 32'hDEADBEEF);
        if (nready == 2) cpu_req = 1'b0;
      end
    end
    repeat (6) begin
      @(negedge sys_clk);
      if (cpu_ready) nready++;
    end
    check("hold_nready", nready, 2);
    check("hold_nacc", q_addr.size() - qb, 4);
    check("hold_idle", {31'b0, cpu_busy}, 32'h0);

    check("stable_outputs", stab_err, 0);
    check("enables_exclusive", both_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
